// File: rtl/mips_isa_pkg.sv
// ---------------------------------------------------------------------------
// mips_isa_pkg
// Shared MIPS encoding constants used by the instruction encoder (and by the
// main controller's decode):
//   - symbolic Operation enum values (0..20); anything above OP_LAST is illegal
//   - I-type opcodes and R-type funct codes
//   - bit positions of the instruction format fields
//   - encoder FSM state type
// ---------------------------------------------------------------------------
package mips_isa_pkg;

  // Symbolic operations presented on the encoder input
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_LW    = 5'd10;
  localparam logic [4:0] OP_SW    = 5'd11;
  localparam logic [4:0] OP_BEQ   = 5'd12;
  localparam logic [4:0] OP_BNE   = 5'd13;
  localparam logic [4:0] OP_ANDI  = 5'd14;
  localparam logic [4:0] OP_ORI   = 5'd15;
  localparam logic [4:0] OP_XORI  = 5'd16;
  localparam logic [4:0] OP_ADDI  = 5'd17;
  localparam logic [4:0] OP_ADDIU = 5'd18;
  localparam logic [4:0] OP_SLTI  = 5'd19;
  localparam logic [4:0] OP_SLTIU = 5'd20;
  localparam logic [4:0] OP_LAST  = 5'd20;

  // Primary opcodes (bits 31:26)
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (bits 5:0)
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Field positions (LSB of each field)
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  // Encoder FSM states
  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FULL   = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instruction_encoder_if.sv
// ---------------------------------------------------------------------------
// instruction_encoder_if
// Groups the symbolic-instruction input handshake and the instruction-memory
// write bus of the instruction encoder.
//   slave  : encoder side (receives instructions, drives memory writes)
//   master : producer / memory side
// ---------------------------------------------------------------------------
interface instruction_encoder_if #(
  parameter int ADDRESS_WIDTH = 8
);
  logic                     In_Valid;
  logic                     In_Ready;
  logic [4:0]               Operation;
  logic [4:0]               Rs;
  logic [4:0]               Rt;
  logic [4:0]               Rd;
  logic [15:0]              Immediate;
  logic                     Memory_Write;
  logic [ADDRESS_WIDTH-1:0] Memory_Address;
  logic [31:0]              Memory_Write_Data;

  modport slave (
    input  In_Valid, Operation, Rs, Rt, Rd, Immediate,
    output In_Ready, Memory_Write, Memory_Address, Memory_Write_Data
  );

  modport master (
    output In_Valid, Operation, Rs, Rt, Rd, Immediate,
    input  In_Ready, Memory_Write, Memory_Address, Memory_Write_Data
  );
endinterface

// File: rtl/instruction_word_builder.sv
// ---------------------------------------------------------------------------
// instruction_word_builder
// Purely combinational: maps a symbolic operation plus register/immediate
// fields onto a 32-bit MIPS machine word. shamt is always zero. Operations
// above OP_LAST raise illegal and produce an all-zero word.
// Ports:
//   operation, rs, rt, rd, immediate : symbolic instruction fields
//   word                             : encoded machine word
//   illegal                          : operation has no encoding
// ---------------------------------------------------------------------------
module instruction_word_builder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  operation,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] immediate,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype;

  // Operation lookup and field packing
  always_comb begin
    opcode   = OPC_RTYPE;
    funct    = 6'h00;
    is_rtype = 1'b0;
    illegal  = 1'b0;
    word     = 32'h0000_0000;

    case (operation)
      OP_ADD:   begin is_rtype = 1'b1; funct = FN_ADD;  end
      OP_ADDU:  begin is_rtype = 1'b1; funct = FN_ADDU; end
      OP_SUB:   begin is_rtype = 1'b1; funct = FN_SUB;  end
      OP_SUBU:  begin is_rtype = 1'b1; funct = FN_SUBU; end
      OP_AND:   begin is_rtype = 1'b1; funct = FN_AND;  end
      OP_OR:    begin is_rtype = 1'b1; funct = FN_OR;   end
      OP_XOR:   begin is_rtype = 1'b1; funct = FN_XOR;  end
      OP_NOR:   begin is_rtype = 1'b1; funct = FN_NOR;  end
      OP_SLT:   begin is_rtype = 1'b1; funct = FN_SLT;  end
      OP_SLTU:  begin is_rtype = 1'b1; funct = FN_SLTU; end
      OP_LW:    opcode = OPC_LW;
      OP_SW:    opcode = OPC_SW;
      OP_BEQ:   opcode = OPC_BEQ;
      OP_BNE:   opcode = OPC_BNE;
      OP_ANDI:  opcode = OPC_ANDI;
      OP_ORI:   opcode = OPC_ORI;
      OP_XORI:  opcode = OPC_XORI;
      OP_ADDI:  opcode = OPC_ADDI;
      OP_ADDIU: opcode = OPC_ADDIU;
      OP_SLTI:  opcode = OPC_SLTI;
      OP_SLTIU: opcode = OPC_SLTIU;
      default:  illegal = 1'b1;
    endcase

    if (illegal) begin
      word = 32'h0000_0000;
    end else if (is_rtype) begin
      word[OPCODE_LSB +: 6] = OPC_RTYPE;
      word[RS_LSB     +: 5] = rs;
      word[RT_LSB     +: 5] = rt;
      word[RD_LSB     +: 5] = rd;
      word[SHAMT_LSB  +: 5] = 5'h00;
      word[FUNCT_LSB  +: 6] = funct;
    end else begin
      // Immediate passes through untouched; extension is the datapath's job
      word[OPCODE_LSB +: 6]  = opcode;
      word[RS_LSB     +: 5]  = rs;
      word[RT_LSB     +: 5]  = rt;
      word[IMM_LSB    +: 16] = immediate;
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
// Accepts symbolic instructions over a valid/ready handshake, encodes each
// into a 32-bit MIPS word and writes it to instruction memory at an
// auto-incrementing word address. One word per two cycles.
// Ports:
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   Restart      : pulse; clears pointer, Full and Error, returns to ACCEPT
//   bus          : instruction input handshake + memory write bus (slave)
//   Word_Count   : words written since Reset/Restart
//   Full         : DEPTH words written, input no longer accepted
//   Error        : sticky, an illegal Operation was accepted
// ---------------------------------------------------------------------------
module instruction_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Restart,
  instruction_encoder_if.slave     bus,
  output logic [ADDRESS_WIDTH:0]   Word_Count,
  output logic                     Full,
  output logic                     Error
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_COUNT = (ADDRESS_WIDTH + 1)'(DEPTH);

  enc_state_t                 state_r;
  enc_state_t                 state_next;
  logic                       in_ready_r;
  logic [31:0]                word_r;
  logic [ADDRESS_WIDTH-1:0]   addr_r;
  logic [ADDRESS_WIDTH:0]     count_r;
  logic                       error_r;

  logic [31:0]                word_s;
  logic                       illegal_s;
  logic                       accept_fire_s;
  logic                       legal_fire_s;
  logic [ADDRESS_WIDTH:0]     count_plus_one_s;

  instruction_word_builder u_builder (
    .operation (bus.Operation),
    .rs        (bus.Rs),
    .rt        (bus.Rt),
    .rd        (bus.Rd),
    .immediate (bus.Immediate),
    .word      (word_s),
    .illegal   (illegal_s)
  );

  // Restart outranks a same-cycle handshake
  assign accept_fire_s    = bus.In_Valid && in_ready_r && !Restart;
  assign legal_fire_s     = accept_fire_s && !illegal_s;
  assign count_plus_one_s = count_r + {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  // Next-state logic
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_ACCEPT: begin
        if (legal_fire_s) begin
          state_next = ST_WRITE;
        end else begin
          state_next = ST_ACCEPT;
        end
      end
      ST_WRITE: begin
        if (count_plus_one_s == DEPTH_COUNT) begin
          state_next = ST_FULL;
        end else begin
          state_next = ST_ACCEPT;
        end
      end
      ST_FULL:  state_next = ST_FULL;
      default:  state_next = ST_ACCEPT;
    endcase
    if (Restart) begin
      state_next = ST_ACCEPT;
    end else begin
      state_next = state_next;
    end
  end

  // State, pointer, captured word and sticky error registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= ST_ACCEPT;
      in_ready_r <= 1'b0;
      word_r     <= 32'h0000_0000;
      addr_r     <= '0;
      count_r    <= '0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_next;
      in_ready_r <= (state_next == ST_ACCEPT);
      if (legal_fire_s) begin
        word_r <= word_s;
        addr_r <= count_r[ADDRESS_WIDTH-1:0];
      end
      if (Restart) begin
        count_r <= '0;
        error_r <= 1'b0;
      end else begin
        if (accept_fire_s && illegal_s) begin
          error_r <= 1'b1;
        end
        if (state_r == ST_WRITE) begin
          count_r <= count_plus_one_s;
        end
      end
    end
  end

  // The strobe is squashed in the same cycle by Reset or Restart so a
  // pending word never reaches memory.
  assign bus.Memory_Write      = (state_r == ST_WRITE) && !Reset && !Restart;
  assign bus.Memory_Address    = addr_r;
  assign bus.Memory_Write_Data = word_r;
  assign bus.In_Ready          = in_ready_r;
  assign Word_Count            = count_r;
  assign Full                  = (state_r == ST_FULL);
  assign Error                 = error_r;

endmodule

// File: tb/tb_instruction_encoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_encoder
// Directed self-checking bench for instruction_encoder, built with DEPTH=4 so
// the Full boundary is reached within the directed sequence. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instruction_encoder;

  logic       Clock;
  logic       Reset;
  logic       Restart;
  logic [8:0] Word_Count;
  logic       Full;
  logic       Error;

  int checks;
  int errors;

  instruction_encoder_if #(.ADDRESS_WIDTH(8)) bus ();

  instruction_encoder #(.ADDRESS_WIDTH(8), .DEPTH(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Restart    (Restart),
    .bus        (bus),
    .Word_Count (Word_Count),
    .Full       (Full),
    .Error      (Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Present an instruction and return at the falling edge of its WRITE cycle
  task automatic handshake(input logic [4:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [15:0] imm);
    int waited;
    bus.Operation = op;
    bus.Rs        = rs;
    bus.Rt        = rt;
    bus.Rd        = rd;
    bus.Immediate = imm;
    bus.In_Valid  = 1'b1;
    waited = 0;
    while (bus.In_Ready !== 1'b1 && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    checks++;
    if (bus.In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout: In_Ready=%b required 1 within 20 cycles", bus.In_Ready);
    end
    @(negedge Clock);
    bus.In_Valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (bus.In_Ready !== 1'b0 || bus.Memory_Write !== 1'b0 || bus.Memory_Address !== 8'h00 ||
        bus.Memory_Write_Data !== 32'h0 || Word_Count !== 9'd0 || Full !== 1'b0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b wr=%b addr=%h data=%h cnt=%0d full=%b err=%b required all 0",
               bus.In_Ready, bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data,
               Word_Count, Full, Error);
    end
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (bus.In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: In_Ready=%b required 1", bus.In_Ready);
    end
  endtask

  task automatic test_add();
    handshake(5'd0, 5'd1, 5'd2, 5'd3, 16'h0000);
    checks++;
    if (bus.Memory_Write !== 1'b1 || bus.Memory_Address !== 8'd0 ||
        bus.Memory_Write_Data !== 32'h0022_1820 || bus.In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL add_write: wr=%b addr=%0d data=%h rdy=%b required 1 0 00221820 0",
               bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data, bus.In_Ready);
    end
    @(negedge Clock);
    checks++;
    if (Word_Count !== 9'd1 || bus.Memory_Write !== 1'b0 || bus.Memory_Address !== 8'd0 ||
        bus.Memory_Write_Data !== 32'h0022_1820) begin
      errors++;
      $display("FAIL add_after: cnt=%0d wr=%b addr=%0d data=%h required 1 0 0 00221820",
               Word_Count, bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data);
    end
  endtask

  task automatic test_lw_beq();
    handshake(5'd10, 5'd29, 5'd8, 5'd0, 16'h0004);
    checks++;
    if (bus.Memory_Write !== 1'b1 || bus.Memory_Address !== 8'd1 ||
        bus.Memory_Write_Data !== 32'h8FA8_0004 || bus.In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL lw_write: wr=%b addr=%0d data=%h rdy=%b required 1 1 8fa80004 0",
               bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data, bus.In_Ready);
    end
    @(negedge Clock);
    handshake(5'd12, 5'd1, 5'd2, 5'd31, 16'hFFFF);
    checks++;
    if (bus.Memory_Write !== 1'b1 || bus.Memory_Address !== 8'd2 ||
        bus.Memory_Write_Data !== 32'h1022_FFFF || bus.In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL beq_write: wr=%b addr=%0d data=%h rdy=%b required 1 2 1022ffff 0",
               bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data, bus.In_Ready);
    end
    @(negedge Clock);
    checks++;
    if (Word_Count !== 9'd3) begin
      errors++;
      $display("FAIL beq_count: Word_Count=%0d required 3", Word_Count);
    end
  endtask

  task automatic test_illegal();
    bus.Operation = 5'd25;
    bus.In_Valid  = 1'b1;
    @(negedge Clock);
    bus.In_Valid = 1'b0;
    checks++;
    if (Error !== 1'b1 || bus.Memory_Write !== 1'b0 || Word_Count !== 9'd3 || bus.In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: err=%b wr=%b cnt=%0d rdy=%b required 1 0 3 1",
               Error, bus.Memory_Write, Word_Count, bus.In_Ready);
    end
    handshake(5'd2, 5'd4, 5'd5, 5'd6, 16'h0000);
    checks++;
    if (bus.Memory_Write !== 1'b1 || bus.Memory_Address !== 8'd3 ||
        bus.Memory_Write_Data !== 32'h0085_3022 || Error !== 1'b1) begin
      errors++;
      $display("FAIL sub_after_illegal: wr=%b addr=%0d data=%h err=%b required 1 3 00853022 1",
               bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data, Error);
    end
  endtask

  task automatic test_full();
    int writes_seen;
    @(negedge Clock);
    checks++;
    if (Full !== 1'b1 || bus.In_Ready !== 1'b0 || Word_Count !== 9'd4) begin
      errors++;
      $display("FAIL full_reached: full=%b rdy=%b cnt=%0d required 1 0 4", Full, bus.In_Ready, Word_Count);
    end
    bus.Operation = 5'd0;
    bus.In_Valid  = 1'b1;
    writes_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (bus.Memory_Write === 1'b1) writes_seen++;
    end
    checks++;
    if (writes_seen != 0 || Word_Count !== 9'd4 || Full !== 1'b1) begin
      errors++;
      $display("FAIL write_when_full: writes=%0d cnt=%0d full=%b required 0 4 1", writes_seen, Word_Count, Full);
    end
    Restart = 1'b1;
    @(negedge Clock);
    Restart = 1'b0;
    bus.In_Valid = 1'b0;
    checks++;
    if (Full !== 1'b0 || Word_Count !== 9'd0 || Error !== 1'b0 || bus.In_Ready !== 1'b1 ||
        bus.Memory_Write !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: full=%b cnt=%0d err=%b rdy=%b wr=%b required 0 0 0 1 0",
               Full, Word_Count, Error, bus.In_Ready, bus.Memory_Write);
    end
    handshake(5'd6, 5'd7, 5'd8, 5'd9, 16'h0000);
    checks++;
    if (bus.Memory_Write !== 1'b1 || bus.Memory_Address !== 8'd0 || bus.Memory_Write_Data !== 32'h00E8_4826) begin
      errors++;
      $display("FAIL xor_after_restart: wr=%b addr=%0d data=%h required 1 0 00e84826",
               bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data);
    end
    @(negedge Clock);
  endtask

  task automatic test_restart_in_write();
    handshake(5'd4, 5'd1, 5'd1, 5'd1, 16'h0000);
    Restart = 1'b1;
    #1;
    checks++;
    if (bus.Memory_Write !== 1'b0) begin
      errors++;
      $display("FAIL restart_suppress: Memory_Write=%b required 0", bus.Memory_Write);
    end
    @(negedge Clock);
    Restart = 1'b0;
    checks++;
    if (Word_Count !== 9'd0 || bus.In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_in_write_count: cnt=%0d rdy=%b required 0 1", Word_Count, bus.In_Ready);
    end
  endtask

  task automatic test_reset_in_write();
    handshake(5'd15, 5'd0, 5'd9, 5'd0, 16'h00FF);
    checks++;
    if (bus.Memory_Write_Data !== 32'h3409_00FF) begin
      errors++;
      $display("FAIL ori_word: data=%h required 340900ff", bus.Memory_Write_Data);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.Memory_Write !== 1'b0) begin
      errors++;
      $display("FAIL reset_suppress: Memory_Write=%b required 0", bus.Memory_Write);
    end
    @(negedge Clock);
    checks++;
    if (bus.In_Ready !== 1'b0 || bus.Memory_Write !== 1'b0 || bus.Memory_Address !== 8'h00 ||
        bus.Memory_Write_Data !== 32'h0 || Word_Count !== 9'd0 || Full !== 1'b0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: rdy=%b wr=%b addr=%h data=%h cnt=%0d full=%b err=%b required all 0",
               bus.In_Ready, bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data,
               Word_Count, Full, Error);
    end
    Reset = 1'b0;
    @(negedge Clock);
    handshake(5'd17, 5'd2, 5'd3, 5'd0, 16'h8000);
    checks++;
    if (bus.Memory_Write !== 1'b1 || bus.Memory_Address !== 8'd0 || bus.Memory_Write_Data !== 32'h2043_8000) begin
      errors++;
      $display("FAIL addi_after_reset: wr=%b addr=%0d data=%h required 1 0 20438000",
               bus.Memory_Write, bus.Memory_Address, bus.Memory_Write_Data);
    end
    @(negedge Clock);
    checks++;
    if (Word_Count !== 9'd1) begin
      errors++;
      $display("FAIL addi_count: Word_Count=%0d required 1", Word_Count);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    Reset         = 1'b1;
    Restart       = 1'b0;
    bus.In_Valid  = 1'b0;
    bus.Operation = 5'd0;
    bus.Rs        = 5'd0;
    bus.Rt        = 5'd0;
    bus.Rd        = 5'd0;
    bus.Immediate = 16'h0000;

    test_reset();
    test_add();
    test_lw_beq();
    test_illegal();
    test_full();
    test_restart_in_write();
    test_reset_in_write();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
